// File: rtl/par_chk_rx.sv
// Serial even-parity receiver: reassembles MSB-first {data, parity} codewords,
// reports parity and framing errors and keeps a saturating parity-error count.
module par_chk_rx #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sin_valid,
   input  logic              sin_bit,
   input  logic              sin_sof,
   input  logic              clr_cnt,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              par_err,
   output logic              frm_err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              busy
);

   localparam int BC_W = $clog2(DATA_W + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] PAR  = 2'd2;

   logic [1:0]        state, state_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [BC_W-1:0]   bit_cnt, bit_cnt_n;
   logic              par_acc, par_acc_n;
   logic              done_n;
   logic              frm_n;

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      par_acc_n = par_acc;
      done_n    = 1'b0;
      frm_n     = 1'b0;
      if (sin_valid) begin
         if (sin_sof) begin
            // A start bit always begins a new codeword, aborting any partial one.
            frm_n     = (state != IDLE);
            shreg_n   = '0;
            shreg_n[0] = sin_bit;
            bit_cnt_n = BC_W'(1);
            par_acc_n = sin_bit;
            state_n   = (DATA_W == 1) ? PAR : DATA;
         end else begin
            case (state)
               DATA: begin
                  shreg_n   = (shreg << 1) | DATA_W'(sin_bit);
                  bit_cnt_n = bit_cnt + BC_W'(1);
                  par_acc_n = par_acc ^ sin_bit;
                  if (bit_cnt == BC_W'(DATA_W - 1))
                     state_n = PAR;
               end
               PAR: begin
                  done_n    = 1'b1;
                  par_acc_n = par_acc ^ sin_bit;
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         par_acc <= 1'b0;
         busy    <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         par_acc <= par_acc_n;
         busy    <= (state_n != IDLE);
         frm_err <= frm_n;
      end
   end

   // Completion stage: result registers and the error counter share one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         par_err    <= 1'b0;
         dout_valid <= 1'b0;
         err_cnt    <= '0;
      end else begin
         dout_valid <= done_n;
         if (done_n) begin
            dout    <= shreg;
            par_err <= par_acc_n;
         end
         if (clr_cnt)
            err_cnt <= '0;
         else if (done_n && par_acc_n && (err_cnt != '1))
            err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule
